// File: rtl/alu_issue_pkg.sv
// Shared encodings for the ALU issue front-end: ALU control codes, request
// opcodes, funct3 values and the decoded-request payload.
package alu_issue_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CTL_W = 4;

  localparam logic [CTL_W-1:0] CTL_ADD  = 4'b0000;
  localparam logic [CTL_W-1:0] CTL_ADDV = 4'b0001;
  localparam logic [CTL_W-1:0] CTL_SUB  = 4'b0010;
  localparam logic [CTL_W-1:0] CTL_SUBV = 4'b0011;
  localparam logic [CTL_W-1:0] CTL_AND  = 4'b0100;
  localparam logic [CTL_W-1:0] CTL_OR   = 4'b0101;
  localparam logic [CTL_W-1:0] CTL_XOR  = 4'b0110;
  localparam logic [CTL_W-1:0] CTL_SLTU = 4'b1000;
  localparam logic [CTL_W-1:0] CTL_SLT  = 4'b1001;
  localparam logic [CTL_W-1:0] CTL_SLL  = 4'b1100;
  localparam logic [CTL_W-1:0] CTL_SRL  = 4'b1101;
  localparam logic [CTL_W-1:0] CTL_SRA  = 4'b1110;

  localparam logic [2:0] OP_OP     = 3'd0;
  localparam logic [2:0] OP_OPIMM  = 3'd1;
  localparam logic [2:0] OP_LUI    = 3'd2;
  localparam logic [2:0] OP_AUIPC  = 3'd3;
  localparam logic [2:0] OP_BRANCH = 3'd4;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [2:0] {
    BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU
  } br_kind_e;

  typedef enum logic [1:0] {SEL_A_RS1, SEL_A_PC, SEL_A_ZERO} sel_a_e;
  typedef enum logic       {SEL_B_RS2, SEL_B_IMM} sel_b_e;

  typedef struct packed {
    logic [CTL_W-1:0] ctl;
    sel_a_e           sel_a;
    sel_b_e           sel_b;
    br_kind_e         br;
    logic             ovf_en;
    logic             illegal;
  } dec_t;

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational decode of op/funct3/funct7b5 into ALU control, operand
// selects, branch kind and the illegal flag.
module alu_ctl_decode
  import alu_issue_pkg::*;
#(
  parameter int unsigned TRAP_OVF = 0
) (
  input  logic [2:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  output dec_t       o_dec_c
);

  localparam logic [CTL_W-1:0] LP_ADD = (TRAP_OVF != 0) ? CTL_ADDV : CTL_ADD;
  localparam logic [CTL_W-1:0] LP_SUB = (TRAP_OVF != 0) ? CTL_SUBV : CTL_SUB;

  logic w_is_op;
  assign w_is_op = (i_op == OP_OP);

  always_comb begin
    o_dec_c.ctl     = LP_ADD;
    o_dec_c.sel_a   = SEL_A_RS1;
    o_dec_c.sel_b   = SEL_B_RS2;
    o_dec_c.br      = BR_NONE;
    o_dec_c.ovf_en  = 1'b0;
    o_dec_c.illegal = 1'b0;
    case (i_op)
      OP_OP, OP_OPIMM: begin
        if (!w_is_op) o_dec_c.sel_b = SEL_B_IMM;
        // funct7b5 is an immediate bit for OP-IMM except on the shifts
        case (i_funct3)
          F3_ADD: begin
            o_dec_c.ctl    = (w_is_op && i_funct7b5) ? LP_SUB : LP_ADD;
            o_dec_c.ovf_en = (TRAP_OVF != 0);
          end
          F3_SLL: begin
            o_dec_c.ctl     = CTL_SLL;
            o_dec_c.illegal = i_funct7b5;
          end
          F3_SLT: begin
            o_dec_c.ctl     = CTL_SLT;
            o_dec_c.illegal = w_is_op & i_funct7b5;
          end
          F3_SLTU: begin
            o_dec_c.ctl     = CTL_SLTU;
            o_dec_c.illegal = w_is_op & i_funct7b5;
          end
          F3_XOR: begin
            o_dec_c.ctl     = CTL_XOR;
            o_dec_c.illegal = w_is_op & i_funct7b5;
          end
          F3_OR: begin
            o_dec_c.ctl     = CTL_OR;
            o_dec_c.illegal = w_is_op & i_funct7b5;
          end
          F3_AND: begin
            o_dec_c.ctl     = CTL_AND;
            o_dec_c.illegal = w_is_op & i_funct7b5;
          end
          default: o_dec_c.ctl = i_funct7b5 ? CTL_SRA : CTL_SRL;
        endcase
      end
      OP_LUI: begin
        o_dec_c.sel_a = SEL_A_ZERO;
        o_dec_c.sel_b = SEL_B_IMM;
      end
      OP_AUIPC: begin
        o_dec_c.sel_a = SEL_A_PC;
        o_dec_c.sel_b = SEL_B_IMM;
      end
      OP_BRANCH: begin
        case (i_funct3)
          F3_BEQ:  begin o_dec_c.ctl = LP_SUB;   o_dec_c.br = BR_EQ;  end
          F3_BNE:  begin o_dec_c.ctl = LP_SUB;   o_dec_c.br = BR_NE;  end
          F3_BLT:  begin o_dec_c.ctl = CTL_SLT;  o_dec_c.br = BR_LT;  end
          F3_BGE:  begin o_dec_c.ctl = CTL_SLT;  o_dec_c.br = BR_GE;  end
          F3_BLTU: begin o_dec_c.ctl = CTL_SLTU; o_dec_c.br = BR_LTU; end
          F3_BGEU: begin o_dec_c.ctl = CTL_SLTU; o_dec_c.br = BR_GEU; end
          default: o_dec_c.illegal = 1'b1;
        endcase
      end
      default: o_dec_c.illegal = 1'b1;
    endcase
    // Illegal requests present a quiet ALU code and carry no side effects
    if (o_dec_c.illegal) begin
      o_dec_c.ctl    = CTL_ADD;
      o_dec_c.br     = BR_NONE;
      o_dec_c.ovf_en = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Issue/writeback front-end for the external execute-stage ALU: S1 drives the
// ALU operands/control, S2 captures the tagged result behind valid/ready.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned TRAP_OVF = 0,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7b5,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [TAG_W-1:0] in_tag,
  output logic [XLEN-1:0]  ALU_DA,
  output logic [XLEN-1:0]  ALU_DB,
  output logic [CTL_W-1:0] ALU_CTL,
  input  logic [XLEN-1:0]  ALU_DC,
  input  logic             ALU_ZERO,
  input  logic             ALU_OverFlow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic             out_taken,
  output logic             out_ovf,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic             ovf_sticky,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] op_count
);

  dec_t w_dec;

  alu_ctl_decode #(.TRAP_OVF(TRAP_OVF)) u_decode (
    .i_op       (in_op),
    .i_funct3   (in_funct3),
    .i_funct7b5 (in_funct7b5),
    .o_dec_c    (w_dec)
  );

  logic             r_s1_valid, r_s1_illegal, r_s1_ovf_en;
  logic [XLEN-1:0]  r_s1_a, r_s1_b;
  logic [CTL_W-1:0] r_s1_ctl;
  br_kind_e         r_s1_br;
  logic [TAG_W-1:0] r_s1_tag;

  logic             r_s2_valid, r_s2_taken, r_s2_ovf, r_s2_illegal;
  logic [XLEN-1:0]  r_s2_result;
  logic [TAG_W-1:0] r_s2_tag;
  logic             r_ovf_sticky;
  logic [CNT_W-1:0] r_op_count;

  logic             w_s2_adv, w_in_ready, w_retire, w_taken;
  logic [XLEN-1:0]  w_opa, w_opb, w_result;

  assign w_s2_adv   = ~r_s2_valid | out_ready;
  assign w_in_ready = ~r_s1_valid | w_s2_adv;
  assign w_retire   = r_s2_valid & out_ready;

  always_comb begin
    w_opa = in_rs1;
    case (w_dec.sel_a)
      SEL_A_PC:   w_opa = in_pc;
      SEL_A_ZERO: w_opa = '0;
      default:    w_opa = in_rs1;
    endcase
    w_opb = (w_dec.sel_b == SEL_B_IMM) ? in_imm : in_rs2;
  end

  // S1: registered operands feeding the ALU
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_a       <= '0;
      r_s1_b       <= '0;
      r_s1_ctl     <= '0;
      r_s1_br      <= BR_NONE;
      r_s1_illegal <= 1'b0;
      r_s1_ovf_en  <= 1'b0;
      r_s1_tag     <= '0;
    end else if (w_in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a       <= w_opa;
        r_s1_b       <= w_opb;
        r_s1_ctl     <= w_dec.ctl;
        r_s1_br      <= w_dec.br;
        r_s1_illegal <= w_dec.illegal;
        r_s1_ovf_en  <= w_dec.ovf_en;
        r_s1_tag     <= in_tag;
      end
    end
  end

  always_comb begin
    w_taken = 1'b0;
    case (r_s1_br)
      BR_EQ:         w_taken = ALU_ZERO;
      BR_NE:         w_taken = ~ALU_ZERO;
      BR_LT, BR_LTU: w_taken = ALU_DC[0];
      BR_GE, BR_GEU: w_taken = ~ALU_DC[0];
      default:       w_taken = 1'b0;
    endcase
    w_result = (r_s1_illegal || (r_s1_br != BR_NONE)) ? '0 : ALU_DC;
  end

  // S2: captured ALU result, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid   <= 1'b0;
      r_s2_result  <= '0;
      r_s2_taken   <= 1'b0;
      r_s2_ovf     <= 1'b0;
      r_s2_illegal <= 1'b0;
      r_s2_tag     <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_result  <= w_result;
        r_s2_taken   <= w_taken;
        r_s2_ovf     <= r_s1_ovf_en & ALU_OverFlow;
        r_s2_illegal <= r_s1_illegal;
        r_s2_tag     <= r_s1_tag;
      end
    end
  end

  // Retire bookkeeping; a same-cycle overflow retire beats ovf_clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_sticky <= 1'b0;
      r_op_count   <= '0;
    end else begin
      if (w_retire && r_s2_ovf) r_ovf_sticky <= 1'b1;
      else if (ovf_clr)         r_ovf_sticky <= 1'b0;
      if (w_retire) r_op_count <= r_op_count + CNT_W'(1);
    end
  end

  assign in_ready    = w_in_ready;
  assign ALU_DA      = r_s1_a;
  assign ALU_DB      = r_s1_b;
  assign ALU_CTL     = r_s1_ctl;
  assign out_valid   = r_s2_valid;
  assign out_result  = r_s2_result;
  assign out_taken   = r_s2_taken;
  assign out_ovf     = r_s2_ovf;
  assign out_illegal = r_s2_illegal;
  assign out_tag     = r_s2_tag;
  assign ovf_sticky  = r_ovf_sticky;
  assign op_count    = r_op_count;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: behavioural ALU beside the DUT, RV32I-level reference
// model feeding an in-order scoreboard, directed cases plus random traffic.
module tb_alu_issue;

  localparam int unsigned TAG_W = 4;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned TRAP  = 1;

  typedef struct packed {
    logic [31:0]      res;
    logic             taken;
    logic             ovf;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk, rst_n;
  logic in_valid, in_ready, in_funct7b5;
  logic [2:0] in_op, in_funct3;
  logic [31:0] in_rs1, in_rs2, in_imm, in_pc;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic [31:0] ALU_DA, ALU_DB, ALU_DC, out_result;
  logic [3:0] ALU_CTL;
  logic ALU_ZERO, ALU_OverFlow;
  logic out_valid, out_ready, out_taken, out_ovf, out_illegal;
  logic ovf_sticky, ovf_clr;
  logic [CNT_W-1:0] op_count;

  int n_checks = 0;
  int n_errors = 0;
  exp_t q[$];
  logic m_sticky = 1'b0;
  logic [CNT_W-1:0] m_count = '0;
  logic stall = 1'b0;
  logic [38:0] hold = '0;
  bit rnd_done;

  alu_issue #(.TAG_W(TAG_W), .TRAP_OVF(TRAP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc),
    .in_tag(in_tag),
    .ALU_DA(ALU_DA), .ALU_DB(ALU_DB), .ALU_CTL(ALU_CTL),
    .ALU_DC(ALU_DC), .ALU_ZERO(ALU_ZERO), .ALU_OverFlow(ALU_OverFlow),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_taken(out_taken), .out_ovf(out_ovf), .out_illegal(out_illegal),
    .out_tag(out_tag), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr),
    .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the external ALU
  always_comb begin
    ALU_DC = 32'h0;
    ALU_OverFlow = 1'b0;
    case (ALU_CTL)
      4'b0000, 4'b0001: ALU_DC = ALU_DA + ALU_DB;
      4'b0010, 4'b0011: ALU_DC = ALU_DA - ALU_DB;
      4'b0100: ALU_DC = ALU_DA & ALU_DB;
      4'b0101: ALU_DC = ALU_DA | ALU_DB;
      4'b0110: ALU_DC = ALU_DA ^ ALU_DB;
      4'b1000: ALU_DC = 32'(ALU_DA < ALU_DB);
      4'b1001: ALU_DC = 32'($signed(ALU_DA) < $signed(ALU_DB));
      4'b1100: ALU_DC = ALU_DA << ALU_DB[4:0];
      4'b1101: ALU_DC = ALU_DA >> ALU_DB[4:0];
      4'b1110: ALU_DC = $signed(ALU_DA) >>> ALU_DB[4:0];
      default: ALU_DC = 32'h0;
    endcase
    if (ALU_CTL == 4'b0001)
      ALU_OverFlow = (ALU_DA[31] == ALU_DB[31]) && (ALU_DC[31] != ALU_DA[31]);
    else if (ALU_CTL == 4'b0011)
      ALU_OverFlow = (ALU_DA[31] != ALU_DB[31]) && (ALU_DC[31] != ALU_DA[31]);
    ALU_ZERO = (ALU_DC == 32'h0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // RV32I semantics of one request
  function automatic exp_t ref_model(input logic [2:0] op, input logic [2:0] f3,
                                     input logic f7, input logic [31:0] a,
                                     input logic [31:0] b, input logic [31:0] imm,
                                     input logic [31:0] pc, input logic [TAG_W-1:0] tag);
    exp_t e;
    logic [31:0] bb;
    longint s;
    logic ill, tk, of;
    ill = 1'b0; tk = 1'b0; of = 1'b0;
    e.res = 32'h0;
    bb = (op == 3'd1) ? imm : b;
    case (op)
      3'd0, 3'd1: begin
        if (op == 3'd0 && f7 && f3 != 3'd0 && f3 != 3'd5) ill = 1'b1;
        case (f3)
          3'd0: begin
            if (op == 3'd0 && f7) begin
              e.res = a - bb;
              s = longint'($signed(a)) - longint'($signed(bb));
            end else begin
              e.res = a + bb;
              s = longint'($signed(a)) + longint'($signed(bb));
            end
            of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
          end
          3'd1: begin e.res = a << bb[4:0]; if (f7) ill = 1'b1; end
          3'd2: e.res = ($signed(a) < $signed(bb)) ? 32'd1 : 32'd0;
          3'd3: e.res = (a < bb) ? 32'd1 : 32'd0;
          3'd4: e.res = a ^ bb;
          3'd5: e.res = f7 ? 32'($signed(a) >>> bb[4:0]) : a >> bb[4:0];
          3'd6: e.res = a | bb;
          default: e.res = a & bb;
        endcase
      end
      3'd2: e.res = imm;
      3'd3: e.res = pc + imm;
      3'd4: begin
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = (a >= b);
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin e.res = 32'h0; tk = 1'b0; end
    e.taken = tk;
    e.ovf   = (TRAP != 0) && of && !ill;
    e.ill   = ill;
    e.tag   = tag;
    return e;
  endfunction

  // Scoreboard and sticky/counter model, sampled on the falling edge
  always @(negedge clk) begin
    exp_t e;
    logic set_now;
    if (!rst_n) begin
      q.delete();
      m_sticky = 1'b0;
      m_count  = '0;
      stall    = 1'b0;
    end else begin
      chk("ovf_sticky", 64'(ovf_sticky), 64'(m_sticky));
      chk("op_count", 64'(op_count), 64'(m_count));
      if (stall)
        chk("stall_hold", 64'({out_valid, out_result, out_taken, out_ovf, out_illegal, out_tag}),
            64'({1'b1, hold}));
      set_now = 1'b0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_retire", 64'(out_valid), 64'(0));
        end else begin
          e = q.pop_front();
          chk("result", 64'(out_result), 64'(e.res));
          chk("taken", 64'(out_taken), 64'(e.taken));
          chk("ovf", 64'(out_ovf), 64'(e.ovf));
          chk("illegal", 64'(out_illegal), 64'(e.ill));
          chk("tag", 64'(out_tag), 64'(e.tag));
          m_count = m_count + 1;
          set_now = e.ovf;
        end
      end
      if (set_now) m_sticky = 1'b1;
      else if (ovf_clr) m_sticky = 1'b0;
      stall = out_valid && !out_ready;
      hold  = {out_result, out_taken, out_ovf, out_illegal, out_tag};
      if (in_valid && in_ready)
        q.push_back(ref_model(in_op, in_funct3, in_funct7b5, in_rs1, in_rs2,
                              in_imm, in_pc, in_tag));
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [2:0] op, input logic [2:0] f3, input logic f7,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] imm, input logic [31:0] pc,
                      input logic [TAG_W-1:0] tag);
    int n;
    bit ok;
    n = 0;
    in_valid = 1'b1; in_op = op; in_funct3 = f3; in_funct7b5 = f7;
    in_rs1 = a; in_rs2 = b; in_imm = imm; in_pc = pc; in_tag = tag;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 500);
    if (!ok) chk("send_timeout", 64'(ok), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 4))
      0: return 32'h7FFFFFFF;
      1: return 32'h80000000;
      2: return 32'($urandom_range(0, 40));
      3: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_funct3 = '0; in_funct7b5 = 1'b0;
    in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_pc = '0; in_tag = '0;
    out_ready = 1'b1; ovf_clr = 1'b0; rnd_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_alu_ctl", 64'(ALU_CTL), 64'(0));
    chk("rst_op_count", 64'(op_count), 64'(0));
    chk("rst_sticky", 64'(ovf_sticky), 64'(0));
    chk("rst_result", 64'(out_result), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // SUB 5-7: two-edge latency, checked-SUB code visible in S1
    send(3'd0, 3'd0, 1'b1, 32'd5, 32'd7, 32'd0, 32'd0, 4'd1);
    @(negedge clk);
    chk("s1_ctl_sub", 64'(ALU_CTL), 64'((TRAP != 0) ? 4'b0011 : 4'b0010));
    chk("s1_not_yet_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    chk("lat2_valid", 64'(out_valid), 64'(1));
    chk("sub_result", 64'(out_result), 64'(32'hFFFFFFFE));
    chk("sub_illegal", 64'(out_illegal), 64'(0));
    @(posedge clk); #1;
    drain();

    // Branch directions
    send(3'd4, 3'd6, 1'b0, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h0, 4'd2);
    send(3'd4, 3'd4, 1'b0, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h0, 4'd3);
    send(3'd4, 3'd0, 1'b0, 32'd3, 32'd3, 32'h0, 32'h0, 4'd4);
    drain();

    // Overflow and sticky flag
    send(3'd0, 3'd0, 1'b0, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h0, 4'd5);
    drain();
    chk("sticky_set", 64'(ovf_sticky), 64'(1));
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    chk("sticky_clr", 64'(ovf_sticky), 64'(0));

    // Illegal OP (AND with f7b5) still retires and counts
    send(3'd0, 3'd7, 1'b1, 32'hFFFF, 32'hF0F0, 32'h0, 32'h0, 4'd6);
    drain();
    chk("illegal_count", 64'(op_count), 64'(m_count));
    chk("illegal_count_abs", 64'(op_count), 64'(6));

    // Backpressure: four back-to-back ops, consumer stalled for three edges
    out_ready = 1'b0;
    fork
      begin
        send(3'd1, 3'd0, 1'b0, 32'd10, 32'd0, 32'd1, 32'd0, 4'd7);
        send(3'd2, 3'd0, 1'b0, 32'd0, 32'd0, 32'h12345000, 32'd0, 4'd8);
        @(negedge clk);
        chk("bp_in_ready_low", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        send(3'd3, 3'd0, 1'b0, 32'd0, 32'd0, 32'h1000, 32'h80, 4'd9);
        send(3'd1, 3'd5, 1'b1, 32'h80000000, 32'd0, 32'h404, 32'd0, 4'd10);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Random traffic with random consumer stalls and ovf_clr pulses
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [2:0] op;
          op = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
          send(op, 3'($urandom), 1'($urandom), rnd32(), rnd32(), rnd32(), rnd32(),
               TAG_W'($urandom));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
          ovf_clr   = ($urandom_range(0, 7) == 0);
        end
      end
    join
    out_ready = 1'b1;
    ovf_clr = 1'b0;
    drain();

    // Reset with two ops in flight
    send(3'd0, 3'd0, 1'b0, 32'd1, 32'd2, 32'd0, 32'd0, 4'd11);
    send(3'd0, 3'd0, 1'b0, 32'd3, 32'd4, 32'd0, 32'd0, 4'd12);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 64'(out_valid), 64'(0));
    chk("rst_mid_op_count", 64'(op_count), 64'(0));
    chk("rst_mid_in_ready", 64'(in_ready), 64'(1));
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_idle", 64'(out_valid), 64'(0));
    end
    chk("post_rst_count", 64'(op_count), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
